// File: rtl/abus_pkg.sv
// rtl/abus_pkg.sv - shared types and constants for the A-bus master
package abus_pkg;

    localparam int ABUS_AW          = 26;
    localparam int ABUS_DW          = 16;
    localparam int ABUS_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } abus_state_t;

    localparam logic [1:0] AREA_CS0  = 2'd0;
    localparam logic [1:0] AREA_CS1  = 2'd1;
    localparam logic [1:0] AREA_CS2  = 2'd2;
    localparam logic [1:0] AREA_NONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;

    // Active-low chip-select vector {ACS2_N, ACS1_N, ACS0_N} for an area code
    function automatic logic [2:0] cs_decode(input logic [1:0] area);
        case (area)
            AREA_CS0: cs_decode = 3'b110;
            AREA_CS1: cs_decode = 3'b101;
            AREA_CS2: cs_decode = 3'b011;
            default:  cs_decode = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/abus_if.sv
// rtl/abus_if.sv - A-bus pin bundle with master and slave views
interface abus_if;
    import abus_pkg::*;

    logic [ABUS_AW-1:0] AA;
    logic [ABUS_DW-1:0] ADI;
    logic [ABUS_DW-1:0] ADO;
    logic               ACS0_N;
    logic               ACS1_N;
    logic               ACS2_N;
    logic               ARD_N;
    logic               AWRU_N;
    logic               AWRL_N;
    logic               AWAIT_N;

    modport master (
        output AA, ADO, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRU_N, AWRL_N,
        input  ADI, AWAIT_N
    );

    modport slave (
        input  AA, ADO, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRU_N, AWRL_N,
        output ADI, AWAIT_N
    );

endinterface

// File: rtl/abus_master.sv
// rtl/abus_master.sv - request-to-A-bus master with wait states, AWAIT_N stretch and timeout
module abus_master
    import abus_pkg::*;
#(
    parameter int TIMEOUT = ABUS_TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        REQ,
    input  logic [1:0]  REQ_AREA,
    input  logic [25:0] REQ_A,
    input  logic [31:0] REQ_D,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SZ,
    output logic [31:0] REQ_Q,
    output logic        ACK,
    output logic        ERR,
    input  logic [11:0] WAIT_CFG,
    abus_if.master      bus
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    abus_state_t r_state, w_state;
    logic [1:0]  r_area, w_area;
    logic [31:0] r_d, w_d;
    logic        r_we, w_we;
    logic [1:0]  r_sz, w_sz;
    logic        r_half, w_half;
    logic [3:0]  r_cnt, w_cnt;
    logic [TW-1:0] r_tmo, w_tmo;
    logic        r_await, w_await;
    logic [15:0] r_adi, w_adi;
    logic [25:0] r_aa, w_aa;
    logic [15:0] r_ado, w_ado;
    logic [2:0]  r_cs_n, w_cs_n;
    logic        r_rd_n, w_rd_n;
    logic        r_wru_n, w_wru_n;
    logic        r_wrl_n, w_wrl_n;
    logic [31:0] r_q, w_q;
    logic        r_err, w_err;
    logic        r_ack, w_ack;

    logic [1:0]  w_req_sz;
    logic [25:0] w_req_aa;
    logic [3:0]  w_wait;

    assign w_req_sz = (REQ_SZ == 2'd3) ? SZ_WORD : REQ_SZ;
    assign w_req_aa = (w_req_sz == SZ_BYTE) ? REQ_A :
                      (w_req_sz == SZ_WORD) ? {REQ_A[25:1], 1'b0} :
                                              {REQ_A[25:2], 2'b00};
    assign w_wait   = (r_area == AREA_CS0) ? WAIT_CFG[3:0] :
                      (r_area == AREA_CS1) ? WAIT_CFG[7:4] : WAIT_CFG[11:8];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_area  <= 2'd0;
            r_d     <= 32'd0;
            r_we    <= 1'b0;
            r_sz    <= 2'd0;
            r_half  <= 1'b0;
            r_cnt   <= 4'd0;
            r_tmo   <= '0;
            r_await <= 1'b1;
            r_adi   <= 16'd0;
            r_aa    <= 26'd0;
            r_ado   <= 16'd0;
            r_cs_n  <= 3'b111;
            r_rd_n  <= 1'b1;
            r_wru_n <= 1'b1;
            r_wrl_n <= 1'b1;
            r_q     <= 32'd0;
            r_err   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_area  <= w_area;
            r_d     <= w_d;
            r_we    <= w_we;
            r_sz    <= w_sz;
            r_half  <= w_half;
            r_cnt   <= w_cnt;
            r_tmo   <= w_tmo;
            r_await <= w_await;
            r_adi   <= w_adi;
            r_aa    <= w_aa;
            r_ado   <= w_ado;
            r_cs_n  <= w_cs_n;
            r_rd_n  <= w_rd_n;
            r_wru_n <= w_wru_n;
            r_wrl_n <= w_wrl_n;
            r_q     <= w_q;
            r_err   <= w_err;
            r_ack   <= w_ack;
        end
    end

    always_comb begin
        w_state = r_state;
        w_area  = r_area;
        w_d     = r_d;
        w_we    = r_we;
        w_sz    = r_sz;
        w_half  = r_half;
        w_cnt   = r_cnt;
        w_tmo   = r_tmo;
        w_await = r_await;
        w_adi   = r_adi;
        w_aa    = r_aa;
        w_ado   = r_ado;
        w_cs_n  = r_cs_n;
        w_rd_n  = r_rd_n;
        w_wru_n = r_wru_n;
        w_wrl_n = r_wrl_n;
        w_q     = r_q;
        w_err   = r_err;
        w_ack   = 1'b0;

        if (CE_F) begin
            w_await = bus.AWAIT_N;
            if (r_state == ST_STROBE) begin
                w_adi = bus.ADI;
            end
        end

        case (r_state)
            ST_IDLE: begin
                // r_ack blocks the requester's REQ that is still high during ACK
                if (CE_R && REQ && !r_ack) begin
                    w_area = REQ_AREA;
                    w_d    = REQ_D;
                    w_we   = REQ_WE;
                    w_sz   = w_req_sz;
                    w_aa   = w_req_aa;
                    w_half = 1'b0;
                    w_cnt  = 4'd0;
                    w_tmo  = '0;
                    w_q    = 32'd0;
                    w_err  = 1'b0;
                    if (REQ_AREA == AREA_NONE) begin
                        w_q     = 32'hFFFF_FFFF;
                        w_err   = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_cs_n  = cs_decode(REQ_AREA);
                        w_state = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (CE_R) begin
                    w_cnt = w_wait;
                    w_tmo = '0;
                    if (r_we) begin
                        case (r_sz)
                            SZ_BYTE: begin
                                w_ado   = {r_d[7:0], r_d[7:0]};
                                w_wru_n = r_aa[0];
                                w_wrl_n = ~r_aa[0];
                            end
                            SZ_WORD: begin
                                w_ado   = r_d[15:0];
                                w_wru_n = 1'b0;
                                w_wrl_n = 1'b0;
                            end
                            default: begin
                                w_ado   = r_half ? r_d[15:0] : r_d[31:16];
                                w_wru_n = 1'b0;
                                w_wrl_n = 1'b0;
                            end
                        endcase
                    end else begin
                        w_rd_n = 1'b0;
                    end
                    w_state = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (CE_R) begin
                    if (r_cnt == 4'd0 && r_await) begin
                        w_rd_n  = 1'b1;
                        w_wru_n = 1'b1;
                        w_wrl_n = 1'b1;
                        if (!r_we) begin
                            case (r_sz)
                                SZ_BYTE: w_q = {24'd0, r_aa[0] ? r_adi[7:0] : r_adi[15:8]};
                                SZ_WORD: w_q = {16'd0, r_adi};
                                default: w_q = r_half ? {r_q[31:16], r_adi} : {r_adi, r_q[15:0]};
                            endcase
                        end
                        w_state = ST_HOLD;
                    end else if (r_cnt != 4'd0) begin
                        w_cnt = r_cnt - 4'd1;
                    end else if (r_tmo == TMO_LAST) begin
                        w_rd_n  = 1'b1;
                        w_wru_n = 1'b1;
                        w_wrl_n = 1'b1;
                        w_cs_n  = 3'b111;
                        w_q     = 32'hFFFF_FFFF;
                        w_err   = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_tmo = r_tmo + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (CE_R) begin
                    if (r_sz == SZ_LONG && !r_half) begin
                        w_half  = 1'b1;
                        w_aa    = r_aa + 26'd2;
                        w_state = ST_SETUP;
                    end else begin
                        w_cs_n  = 3'b111;
                        w_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_ack   = 1'b1;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign bus.AA     = r_aa;
    assign bus.ADO    = r_ado;
    assign bus.ACS0_N = r_cs_n[0];
    assign bus.ACS1_N = r_cs_n[1];
    assign bus.ACS2_N = r_cs_n[2];
    assign bus.ARD_N  = r_rd_n;
    assign bus.AWRU_N = r_wru_n;
    assign bus.AWRL_N = r_wrl_n;
    assign REQ_Q      = r_q;
    assign ACK        = r_ack;
    assign ERR        = r_err;

endmodule

// File: tb/tb_abus_master.sv
// tb/tb_abus_master.sv - scoreboard bench for abus_master
module tb_abus_master;
    import abus_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE_R = 1'b0;
    logic        CE_F = 1'b0;
    logic        REQ = 1'b0;
    logic [1:0]  REQ_AREA = 2'd0;
    logic [25:0] REQ_A = 26'd0;
    logic [31:0] REQ_D = 32'd0;
    logic        REQ_WE = 1'b0;
    logic [1:0]  REQ_SZ = 2'd0;
    logic [31:0] REQ_Q;
    logic        ACK;
    logic        ERR;
    logic [11:0] WAIT_CFG = 12'h102;

    logic        phase = 1'b0;
    logic [15:0] adi_const = 16'd0;
    logic        adi_by_addr = 1'b0;

    abus_if bus ();

    assign bus.ADI = adi_by_addr ? (bus.AA[15:0] ^ 16'hC0DE) : adi_const;

    abus_master #(.TIMEOUT(1024)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CE_R     (CE_R),
        .CE_F     (CE_F),
        .REQ      (REQ),
        .REQ_AREA (REQ_AREA),
        .REQ_A    (REQ_A),
        .REQ_D    (REQ_D),
        .REQ_WE   (REQ_WE),
        .REQ_SZ   (REQ_SZ),
        .REQ_Q    (REQ_Q),
        .ACK      (ACK),
        .ERR      (ERR),
        .WAIT_CFG (WAIT_CFG),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    // Bus tick every other cycle; sample enable on the alternate cycle
    always @(negedge CLK) begin
        phase = ~phase;
        CE_R  = phase;
        CE_F  = ~phase;
    end

    typedef struct {
        logic [31:0] q;
        logic        chk_q;
        logic        err;
    } ack_exp_t;

    typedef struct {
        logic [25:0] aa;
        logic [15:0] ado;
        logic        chk_ado;
        logic [2:0]  cs_n;
        logic        rd_n;
        logic        wru_n;
        logic        wrl_n;
        int          width;
    } bus_exp_t;

    ack_exp_t ack_q[$];
    bus_exp_t bus_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_ack(input logic [31:0] q, input logic chk_q, input logic err);
        ack_exp_t e;
        e.q = q; e.chk_q = chk_q; e.err = err;
        ack_q.push_back(e);
    endfunction

    function automatic void push_bus(input logic [25:0] aa, input logic [15:0] ado, input logic chk_ado,
                                     input logic [2:0] cs_n, input logic rd_n, input logic wru_n,
                                     input logic wrl_n, input int width);
        bus_exp_t e;
        e.aa = aa; e.ado = ado; e.chk_ado = chk_ado; e.cs_n = cs_n;
        e.rd_n = rd_n; e.wru_n = wru_n; e.wrl_n = wrl_n; e.width = width;
        bus_q.push_back(e);
    endfunction

    ack_exp_t ack_e;
    always @(negedge CLK) begin
        if (ACK === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                ack_e = ack_q.pop_front();
                if (ack_e.chk_q) check("ack_req_q", REQ_Q, ack_e.q);
                check("ack_err", ERR, ack_e.err);
            end
        end
    end

    logic     strobe_act;
    logic     prev_act = 1'b0;
    logic     have_cur = 1'b0;
    int       wcnt = 0;
    int       cs_low_cycles = 0;
    bus_exp_t cur;
    always @(negedge CLK) begin
        strobe_act = !(bus.ARD_N && bus.AWRU_N && bus.AWRL_N);
        if (!(bus.ACS0_N && bus.ACS1_N && bus.ACS2_N)) cs_low_cycles++;
        if (strobe_act && !prev_act) begin
            wcnt = 1;
            if (bus_q.size() == 0) begin
                have_cur = 1'b0;
                checks++;
                failures++;
                $display("FAIL unexpected_strobe aa=%0h", bus.AA);
            end else begin
                have_cur = 1'b1;
                cur = bus_q.pop_front();
                check("bus_aa", bus.AA, cur.aa);
                check("bus_cs_n", {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N}, cur.cs_n);
                check("bus_strobes", {bus.ARD_N, bus.AWRU_N, bus.AWRL_N},
                      {cur.rd_n, cur.wru_n, cur.wrl_n});
                if (cur.chk_ado) check("bus_ado", bus.ADO, cur.ado);
            end
        end else if (strobe_act) begin
            wcnt++;
        end else if (prev_act && have_cur && cur.width > 0) begin
            check("strobe_width_cycles", wcnt, cur.width);
        end
        prev_act = strobe_act;
    end

    task automatic start_req(input logic [1:0] area, input logic [25:0] a, input logic [31:0] d,
                             input logic we, input logic [1:0] sz);
        @(negedge CLK);
        REQ_AREA = area;
        REQ_A    = a;
        REQ_D    = d;
        REQ_WE   = we;
        REQ_SZ   = sz;
        REQ      = 1'b1;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (ACK === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_ack_timeout actual=no_ack required=ack", name);
        end
        @(posedge CLK);
        #1 REQ = 1'b0;
    endtask

    task automatic wait_rd_low(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.ARD_N === 1'b0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_no_read_strobe actual=1 required=0", name);
        end
    endtask

    int cs_base;

    initial begin
        bus.AWAIT_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_aa", bus.AA, 26'd0);
        check("rst_ado", bus.ADO, 16'd0);
        check("rst_req_q", REQ_Q, 32'd0);
        check("rst_ack_err", {ACK, ERR}, 2'b00);
        check("rst_pins", {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRU_N, bus.AWRL_N}, 6'h3F);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // CS0 word read, WAIT=2: strobe 3 ticks = 6 cycles
        adi_const = 16'h1234;
        push_bus(26'h0000010, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 6);
        push_ack(32'h0000_1234, 1'b1, 1'b0);
        start_req(AREA_CS0, 26'h0000010, 32'd0, 1'b0, SZ_WORD);
        wait_ack("cs0_word_read");

        // CS1 long write, WAIT=0, misaligned address
        push_bus(26'h0000100, 16'hAABB, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 2);
        push_bus(26'h0000102, 16'hCCDD, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 2);
        push_ack(32'd0, 1'b0, 1'b0);
        start_req(AREA_CS1, 26'h0000102, 32'hAABB_CCDD, 1'b1, SZ_LONG);
        wait_ack("cs1_long_write");

        // CS2 byte writes, WAIT=1: odd -> lower strobe, even -> upper strobe
        push_bus(26'h0000201, 16'h5A5A, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 4);
        push_ack(32'd0, 1'b0, 1'b0);
        start_req(AREA_CS2, 26'h0000201, 32'h0000_005A, 1'b1, SZ_BYTE);
        wait_ack("cs2_byte_write_odd");
        push_bus(26'h0000200, 16'hC3C3, 1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 4);
        push_ack(32'd0, 1'b0, 1'b0);
        start_req(AREA_CS2, 26'h0000200, 32'h0000_00C3, 1'b1, SZ_BYTE);
        wait_ack("cs2_byte_write_even");

        // CS0 long read; ADI follows AA so halves differ
        adi_by_addr = 1'b1;
        push_bus(26'h0000030, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 6);
        push_bus(26'h0000032, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 6);
        push_ack(32'hC0EE_C0EC, 1'b1, 1'b0);
        start_req(AREA_CS0, 26'h0000033, 32'd0, 1'b0, SZ_LONG);
        wait_ack("cs0_long_read");
        adi_by_addr = 1'b0;

        // CS1 byte reads: odd picks low byte, even picks high byte
        adi_const = 16'hBEEF;
        push_bus(26'h0000041, 16'd0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b1, 2);
        push_ack(32'h0000_00EF, 1'b1, 1'b0);
        start_req(AREA_CS1, 26'h0000041, 32'd0, 1'b0, SZ_BYTE);
        wait_ack("cs1_byte_read_odd");
        push_bus(26'h0000040, 16'd0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b1, 2);
        push_ack(32'h0000_00BE, 1'b1, 1'b0);
        start_req(AREA_CS1, 26'h0000040, 32'd0, 1'b0, SZ_BYTE);
        wait_ack("cs1_byte_read_even");

        // Size code 3 behaves as word; AA[0] forced low
        adi_const = 16'h7E81;
        push_bus(26'h0000054, 16'd0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 4);
        push_ack(32'h0000_7E81, 1'b1, 1'b0);
        start_req(AREA_CS2, 26'h0000055, 32'd0, 1'b0, 2'd3);
        wait_ack("cs2_size3_read");

        // AWAIT_N held low, released 10 cycles into the strobe: 12-cycle strobe
        adi_const = 16'h1111;
        bus.AWAIT_N = 1'b0;
        push_bus(26'h0000060, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 12);
        push_ack(32'h0000_1111, 1'b1, 1'b0);
        start_req(AREA_CS0, 26'h0000060, 32'd0, 1'b0, SZ_WORD);
        wait_rd_low("await_ext");
        repeat (10) @(negedge CLK);
        bus.AWAIT_N = 1'b1;
        wait_ack("await_ext");

        // AWAIT_N stuck low: 2 wait ticks + 1024 stretch ticks, then abort
        bus.AWAIT_N = 1'b0;
        push_bus(26'h0000070, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 2052);
        push_ack(32'hFFFF_FFFF, 1'b1, 1'b1);
        start_req(AREA_CS0, 26'h0000070, 32'd0, 1'b0, SZ_WORD);
        wait_ack("timeout");
        bus.AWAIT_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Unmapped area: no chip select, error response
        cs_base = cs_low_cycles;
        push_ack(32'hFFFF_FFFF, 1'b1, 1'b1);
        start_req(AREA_NONE, 26'h0000090, 32'd0, 1'b0, SZ_WORD);
        wait_ack("area3");
        check("area3_no_cs_cycles", cs_low_cycles - cs_base, 0);

        // Reset during STROBE: pins release at once, no ACK
        push_bus(26'h0000080, 16'd0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 0);
        start_req(AREA_CS0, 26'h0000080, 32'd0, 1'b0, SZ_WORD);
        wait_rd_low("mid_reset");
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_pins", {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRU_N, bus.AWRL_N}, 6'h3F);
        check("midrst_aa", bus.AA, 26'd0);
        check("midrst_req_q_ack", {REQ_Q, ACK, ERR}, 34'd0);
        REQ = 1'b0;
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        repeat (30) @(negedge CLK);

        check("ack_queue_empty", ack_q.size(), 0);
        check("bus_queue_empty", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/abus_master.md
ABUS_MASTER -- requirements
Module: abus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, max CE_R ticks a strobe may be stretched by AWAIT_N before abort.
REQ-002 SHALL have port CLK  in  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port CE_R  in  1  bus-tick enable; all A-bus output changes occur only on CLK edges with CE_R=1.
REQ-005 SHALL have port CE_F  in  1  sample enable; AWAIT_N and ADI are sampled only on CLK edges with CE_F=1.
REQ-006 SHALL have port REQ  in  1  request, held high by the requester until ACK.
REQ-007 SHALL have port REQ_AREA  in  2  target: 0=CS0, 1=CS1, 2=CS2, 3=unmapped.
REQ-008 SHALL have port REQ_A  in  26  byte address.
REQ-009 SHALL have port REQ_D  in  32  write data, right-aligned for byte/word.
REQ-010 SHALL have port REQ_WE  in  1  1=write, 0=read.
REQ-011 SHALL have port REQ_SZ  in  2  0=byte, 1=word, 2=long; 3 treated as word.
REQ-012 SHALL have port REQ_Q  out  32  read data, right-aligned, valid with ACK.
REQ-013 SHALL have port ACK  out  1  one-CLK completion pulse.
REQ-014 SHALL have port ERR  out  1  valid with ACK; 1=timeout or unmapped area.
REQ-015 SHALL have port WAIT_CFG  in  12  static wait states, [3:0] CS0, [7:4] CS1, [11:8] CS2.
REQ-016 SHALL have port AA  out  26  A-bus address.
REQ-017 SHALL have port ADI  in  16  A-bus read data.
REQ-018 SHALL have port ADO  out  16  A-bus write data.
REQ-019 SHALL have ports ACS0_N, ACS1_N, ACS2_N  out  1 each  chip selects, active-low.
REQ-020 SHALL have ports ARD_N, AWRU_N, AWRL_N  out  1 each  read, upper-byte write, lower-byte write strobes, active-low.
REQ-021 SHALL have port AWAIT_N  in  1  responder wait, active-low.

Function
REQ-022 SHALL implement states IDLE, SETUP, STROBE, HOLD, DONE; each non-DONE transition occurs on a CE_R tick.
REQ-023 IDLE: SHALL accept when REQ=1 and ACK=0, latch all REQ_* fields, drive AA and the selected ACSx_N low, go SETUP; area 3 goes directly to DONE with REQ_Q=FFFFFFFF, ERR=1, no strobes.
REQ-024 SETUP: after one tick SHALL assert ARD_N (read) or write strobes, drive ADO, load wait counter with the area's WAIT_CFG nibble, go STROBE.
REQ-025 STROBE: SHALL decrement counter per tick; exit to HOLD on the first tick where counter=0 and last CE_F-sampled AWAIT_N=1; read data = ADI sampled on the last CE_F before exit.
REQ-026 Minimum strobe width SHALL be WAIT+1 CE_R ticks; AWAIT_N low extends it indefinitely up to TIMEOUT ticks.
REQ-027 On TIMEOUT reached in STROBE SHALL deassert strobes and chip select, go DONE with ERR=1, REQ_Q=FFFFFFFF.
REQ-028 HOLD: SHALL deassert strobes, keep ACSx_N and AA one tick; then for first half of a long go SETUP with AA+2, else release ACSx_N, go DONE.
REQ-029 DONE: SHALL pulse ACK for exactly one CLK, return to IDLE; requester drops REQ the cycle after ACK; REQ seen during ACK SHALL NOT start a new access.
REQ-030 Byte write: even address SHALL assert only AWRU_N with REQ_D[7:0] on ADO[15:8], odd only AWRL_N on ADO[7:0]; other ADO byte duplicates the data.
REQ-031 Byte read SHALL return ADI[15:8] (even) or ADI[7:0] (odd) in REQ_Q[7:0], upper bits zero; word read returns ADI in REQ_Q[15:0].
REQ-032 AA[0] SHALL be 0 for word/long; long SHALL access REQ_A&~3 then +2, REQ_Q[31:16]/REQ_D[31:16] first half; REQ_A misalignment ignored.
REQ-033 AA SHALL wrap modulo 2^26 on +2.

Reset
REQ-034 RST_N low SHALL immediately, even mid-access, force IDLE, all ACSx_N/ARD_N/AWRx_N=1, AA=0, ADO=0, REQ_Q=0, ACK=0, ERR=0, counters 0; no ACK for the aborted access.

Structure
REQ-035 Package abus_pkg SHALL hold the state enum, area codes, size codes and default TIMEOUT; single module, no sub-module.

Verification
REQ-036 CS0 word read, WAIT=2, AWAIT_N=1, ADI=1234 -> ARD_N low exactly 3 CE_R ticks, ACK once, REQ_Q=00001234, ERR=0.
REQ-037 CS1 long write A=0000102 D=AABBCCDD WAIT=0 -> AA=0000100 with ADO=AABB, then AA=0000102 with ADO=CCDD, both strobes low each half, one ACK.
REQ-038 CS2 byte write A=...1 D=5A -> only AWRL_N low, ADO[7:0]=5A; A=...0 -> only AWRU_N low.
REQ-039 CS0 read, AWAIT_N low 5 ticks then high -> strobe extended, ACK after release, ERR=0; AWAIT_N stuck low -> abort after 1024 ticks, ERR=1, REQ_Q=FFFFFFFF.
REQ-040 Area 3 read -> no chip select/strobe, ACK next CE_R with ERR=1; RST_N low during STROBE -> all strobes high same cycle, no ACK.
